// File: rtl/add_sub_pipe.sv
// Pipelined WIDTH-bit add/subtract with carry-segmented stages, valid/ready flow
// control, carry-out, signed/unsigned overflow and sign flags, and optional saturation.
module add_sub_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             ALUFun,
    input  logic             Sign,
    input  logic             Sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Z,
    output logic             V,
    output logic             N,
    output logic             C
);

    localparam int SEG = WIDTH / STAGES;

    if (STAGES < 1 || STAGES > 8 || (WIDTH % STAGES) != 0) begin : g_bad_params
        $error("add_sub_pipe: STAGES must be 1..8 and divide WIDTH");
    end

    // Valid/ready contract: a bundle transfers on an edge where in_valid & in_ready;
    // a result is consumed on an edge where out_valid & out_ready. The whole pipe
    // moves as one (adv), so in_ready is simply adv and needs no skid storage.
    logic             adv;
    logic             out_valid_q;
    logic [WIDTH-1:0] s_q;
    logic             z_q, v_q, n_q, c_q;

    assign adv       = ~out_valid_q | out_ready;
    assign in_ready  = adv;
    assign out_valid = out_valid_q;
    assign S         = s_q;
    assign Z         = z_q;
    assign V         = v_q;
    assign N         = n_q;
    assign C         = c_q;

    for (genvar k = 0; k < STAGES; k++) begin : g_st
        // REM: operand bits still to be summed on entry; ACC: result bits known on exit.
        localparam int REM = WIDTH - k * SEG;
        localparam int ACC = (k + 1) * SEG;

        logic [REM-1:0] a_in, b_in;
        logic           cy_in, fun_in, sign_in, sat_in, vld_in;
        logic [ACC-1:0] acc;
        logic [SEG:0]   seg_sum;

        assign seg_sum = {1'b0, a_in[SEG-1:0]} + {1'b0, b_in[SEG-1:0]}
                       + {{SEG{1'b0}}, cy_in};

        if (k == 0) begin : g_src
            // Subtract is A + ~B + 1: the +1 rides in as the first segment's carry.
            assign a_in    = A;
            assign b_in    = ALUFun ? ~B : B;
            assign cy_in   = ALUFun;
            assign fun_in  = ALUFun;
            assign sign_in = Sign;
            assign sat_in  = Sat;
            assign vld_in  = in_valid;
            assign acc     = seg_sum[SEG-1:0];
        end else begin : g_src
            assign a_in    = g_st[k-1].g_reg.a_q;
            assign b_in    = g_st[k-1].g_reg.b_q;
            assign cy_in   = g_st[k-1].g_reg.cy_q;
            assign fun_in  = g_st[k-1].g_reg.fun_q;
            assign sign_in = g_st[k-1].g_reg.sign_q;
            assign sat_in  = g_st[k-1].g_reg.sat_q;
            assign vld_in  = g_st[k-1].g_reg.vld_q;
            assign acc     = {seg_sum[SEG-1:0], g_st[k-1].g_reg.acc_q};
        end

        if (k < STAGES - 1) begin : g_reg
            logic [REM-SEG-1:0] a_q, b_q;
            logic [ACC-1:0]     acc_q;
            logic               vld_q, cy_q, fun_q, sign_q, sat_q;

            always_ff @(posedge clk) begin
                if (reset) begin
                    vld_q  <= 1'b0;
                    a_q    <= '0;
                    b_q    <= '0;
                    acc_q  <= '0;
                    cy_q   <= 1'b0;
                    fun_q  <= 1'b0;
                    sign_q <= 1'b0;
                    sat_q  <= 1'b0;
                end else if (adv) begin
                    vld_q <= vld_in;
                    // Bubbles leave the data untouched so idle operands cannot leak in.
                    if (vld_in) begin
                        a_q    <= a_in[REM-1:SEG];
                        b_q    <= b_in[REM-1:SEG];
                        acc_q  <= acc;
                        cy_q   <= seg_sum[SEG];
                        fun_q  <= fun_in;
                        sign_q <= sign_in;
                        sat_q  <= sat_in;
                    end
                end
            end
        end else begin : g_out
            logic [WIDTH-1:0] s_d;
            logic             c_d, ovf_s, ovf_u, v_d, n_d, z_d;

            always_comb begin
                c_d   = seg_sum[SEG];
                // a_in/b_in here hold only the top segment, so [SEG-1] is the operand MSB.
                ovf_s = (a_in[SEG-1] == b_in[SEG-1]) & (acc[WIDTH-1] != a_in[SEG-1]);
                ovf_u = fun_in ? ~c_d : c_d;
                v_d   = sign_in ? ovf_s : ovf_u;
                n_d   = sign_in ? (acc[WIDTH-1] ^ ovf_s) : (fun_in & ~c_d);
                s_d   = acc;
                if (sat_in && v_d) begin
                    if (sign_in) begin
                        s_d = n_d ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
                    end else begin
                        s_d = fun_in ? '0 : '1;
                    end
                end
                z_d = (s_d == '0);
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    out_valid_q <= 1'b0;
                    s_q         <= '0;
                    z_q         <= 1'b0;
                    v_q         <= 1'b0;
                    n_q         <= 1'b0;
                    c_q         <= 1'b0;
                end else if (adv) begin
                    out_valid_q <= vld_in;
                    if (vld_in) begin
                        s_q <= s_d;
                        z_q <= z_d;
                        v_q <= v_d;
                        n_q <= n_d;
                        c_q <= c_d;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_add_sub_pipe.sv
// Bench for add_sub_pipe: STAGES=2 and STAGES=4 instances on shared operands,
// an arithmetic reference model with scoreboards, directed cases and random traffic.
module tb_add_sub_pipe;

    localparam int W  = 32;
    localparam int EW = W + 4;   // {S, Z, V, N, C}

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic [W-1:0] A, B;
    logic         alu_fun, sgn, sat;

    logic         in_ready2, out_valid2, out_ready2;
    logic [W-1:0] S2;
    logic         Z2, V2, N2, C2;
    logic         in_ready4, out_valid4, out_ready4;
    logic [W-1:0] S4;
    logic         Z4, V4, N4, C4;

    int n_pass  = 0;
    int n_total = 0;

    logic [EW-1:0] exp2_q[$];
    logic [EW-1:0] exp4_q[$];

    always #5 clk = ~clk;

    add_sub_pipe #(.WIDTH(W), .STAGES(2)) dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
        .A(A), .B(B), .ALUFun(alu_fun), .Sign(sgn), .Sat(sat),
        .out_valid(out_valid2), .out_ready(out_ready2),
        .S(S2), .Z(Z2), .V(V2), .N(N2), .C(C2)
    );

    add_sub_pipe #(.WIDTH(W), .STAGES(4)) dut4 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready4),
        .A(A), .B(B), .ALUFun(alu_fun), .Sign(sgn), .Sat(sat),
        .out_valid(out_valid4), .out_ready(out_ready4),
        .S(S4), .Z(Z4), .V(V4), .N(N4), .C(C4)
    );

    // Reference: exact integer result, then range tests for overflow and clamping.
    function automatic logic [EW-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic fun, input logic sg, input logic st);
        longint       ta, tb, t;
        logic [W:0]   wide_sum;
        logic [W-1:0] s;
        logic         v, n, c;
        if (sg) begin
            ta = longint'(signed'(a));
            tb = longint'(signed'(b));
        end else begin
            ta = longint'({32'b0, a});
            tb = longint'({32'b0, b});
        end
        t = fun ? (ta - tb) : (ta + tb);
        if (sg) v = (t > 64'sd2147483647) || (t < -64'sd2147483648);
        else    v = (t > 64'sd4294967295) || (t < 64'sd0);
        n = (t < 64'sd0);
        wide_sum = {1'b0, a} + {1'b0, b};
        c = fun ? (a >= b) : wide_sum[W];
        s = t[W-1:0];
        if (st && v) begin
            if (sg) s = n ? 32'h8000_0000 : 32'h7FFF_FFFF;
            else    s = n ? 32'h0000_0000 : 32'hFFFF_FFFF;
        end
        return {s, (s == '0), v, n, c};
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'hFFFF_FFFF;
            5:       return 32'h0000_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    // Scoreboards: compare the head every cycle a result is presented, pop on handshake.
    always @(negedge clk) begin
        if (reset) begin
            exp2_q.delete();
        end else begin
            check("in_ready2", {63'b0, in_ready2}, {63'b0, (~out_valid2 | out_ready2)});
            if (out_valid2) begin
                if (exp2_q.size() == 0) begin
                    n_total++;
                    $display("FAIL out2_unexpected: got S=%h expected no result", S2);
                end else begin
                    check("result2", {S2, Z2, V2, N2, C2}, exp2_q[0]);
                    if (out_ready2) void'(exp2_q.pop_front());
                end
            end
            if (in_valid && in_ready2) exp2_q.push_back(model(A, B, alu_fun, sgn, sat));
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            exp4_q.delete();
        end else begin
            if (out_valid4) begin
                if (exp4_q.size() == 0) begin
                    n_total++;
                    $display("FAIL out4_unexpected: got S=%h expected no result", S4);
                end else begin
                    check("result4", {S4, Z4, V4, N4, C4}, exp4_q[0]);
                    if (out_ready4) void'(exp4_q.pop_front());
                end
            end
            if (in_valid && in_ready4) exp4_q.push_back(model(A, B, alu_fun, sgn, sat));
        end
    end

    task automatic present(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic fun, input logic sg, input logic st);
        A = a; B = b; alu_fun = fun; sgn = sg; sat = st;
        in_valid = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            A = $urandom; B = $urandom;
            alu_fun = 1'($urandom_range(0, 1));
            sgn = 1'($urandom_range(0, 1));
            sat = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; A = '0; B = '0;
        alu_fun = 1'b0; sgn = 1'b0; sat = 1'b0;
        out_ready2 = 1'b1; out_ready4 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out2", {S2, Z2, V2, N2, C2, out_valid2}, 64'd0);
        check("rst_out4", {S4, Z4, V4, N4, C4, out_valid4}, 64'd0);
        reset = 1'b0;
        check("rst_in_ready", {in_ready2, in_ready4}, 64'd3);

        // Hand-computed values that pin the reference model.
        check("pin_sovf_add",     model(32'h7FFF_FFFF, 32'd1, 0, 1, 0), {32'h8000_0000, 4'b0100});
        check("pin_sovf_add_sat", model(32'h7FFF_FFFF, 32'd1, 0, 1, 1), {32'h7FFF_FFFF, 4'b0100});
        check("pin_sovf_sub_sat", model(32'h8000_0000, 32'd1, 1, 1, 1), {32'h8000_0000, 4'b0111});
        check("pin_usub",         model(32'd3, 32'd5, 1, 0, 0),         {32'hFFFF_FFFE, 4'b0110});
        check("pin_usub_sat",     model(32'd3, 32'd5, 1, 0, 1),         {32'h0000_0000, 4'b1110});
        check("pin_uadd_sat",     model(32'hFFFF_FFFF, 32'd2, 0, 0, 1), {32'hFFFF_FFFF, 4'b0101});
        check("pin_seg_carry",    model(32'h0000_FFFF, 32'd1, 0, 0, 0), {32'h0001_0000, 4'b0000});
        check("pin_sub_zero",     model(32'd5, 32'd5, 1, 0, 0),         {32'h0000_0000, 4'b1001});
        check("pin_uadd_wrap",    model(32'hFFFF_FFFF, 32'd1, 0, 0, 0), {32'h0000_0000, 4'b1101});
        check("pin_ssub_neg",     model(32'h10, 32'h20, 1, 1, 0),       {32'hFFFF_FFF0, 4'b0010});

        // Latency: visible STAGES cycles after the presenting cycle.
        present(32'h0000_FFFF, 32'd1, 0, 0, 0);
        check("lat2_c1", {63'b0, out_valid2}, 64'd0);
        check("lat4_c1", {63'b0, out_valid4}, 64'd0);
        idle(1);
        check("lat2_c2", {S2, out_valid2}, {32'h0001_0000, 1'b1});
        check("lat4_c2", {63'b0, out_valid4}, 64'd0);
        idle(1);
        check("lat4_c3", {63'b0, out_valid4}, 64'd0);
        idle(1);
        check("lat4_c4", {S4, out_valid4}, {32'h0001_0000, 1'b1});
        idle(3);

        // Overflow and saturation cases through both pipes.
        present(32'h7FFF_FFFF, 32'd1, 0, 1, 0);
        present(32'h7FFF_FFFF, 32'd1, 0, 1, 1);
        present(32'h8000_0000, 32'd1, 1, 1, 1);
        present(32'd3, 32'd5, 1, 0, 0);
        present(32'd3, 32'd5, 1, 0, 1);
        present(32'hFFFF_FFFF, 32'd2, 0, 0, 1);
        idle(6);

        // Segment carry and ordering, back to back.
        present(32'h0000_FFFF, 32'd1, 0, 0, 0);
        present(32'd5, 32'd5, 1, 0, 0);
        check("seg2_r0", {S2, Z2, V2, N2, C2, out_valid2}, {32'h0001_0000, 4'b0000, 1'b1});
        present(32'hFFFF_FFFF, 32'd1, 0, 0, 0);
        check("seg2_r1", {S2, Z2, V2, N2, C2, out_valid2}, {32'h0000_0000, 4'b1001, 1'b1});
        idle(1);
        check("seg2_r2", {S2, Z2, V2, N2, C2, out_valid2}, {32'h0000_0000, 4'b1101, 1'b1});
        check("seg4_r0", {S4, Z4, V4, N4, C4, out_valid4}, {32'h0001_0000, 4'b0000, 1'b1});
        idle(1);
        check("seg4_r1", {S4, Z4, V4, N4, C4, out_valid4}, {32'h0000_0000, 4'b1001, 1'b1});
        idle(1);
        check("seg4_r2", {S4, Z4, V4, N4, C4, out_valid4}, {32'h0000_0000, 4'b1101, 1'b1});
        idle(4);

        // Backpressure on the STAGES=2 pipe.
        out_ready2 = 1'b0;
        present(32'h1234_5678, 32'h1111_1111, 0, 0, 0);
        present(32'h10, 32'h20, 1, 1, 0);
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("bp_in_ready", {62'b0, in_ready2, out_valid2}, 64'd1);
            check("bp_hold", {S2, Z2, V2, N2, C2}, {32'h2345_6789, 4'b0000});
            if (i < 2) idle(1);
        end
        out_ready2 = 1'b1;
        idle(1);
        check("bp_drain1", {S2, Z2, V2, N2, C2, out_valid2}, {32'hFFFF_FFF0, 4'b0010, 1'b1});
        idle(1);
        check("bp_drain2", {63'b0, out_valid2}, 64'd0);
        idle(4);

        // Reset with operations in flight.
        present(32'd100, 32'd7, 0, 0, 0);
        present(32'd9, 32'd4, 1, 1, 0);
        reset = 1'b1;
        idle(1);
        check("midrst_out2", {S2, Z2, V2, N2, C2, out_valid2}, 64'd0);
        check("midrst_out4", {S4, Z4, V4, N4, C4, out_valid4}, 64'd0);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("midrst_quiet", {62'b0, out_valid2, out_valid4}, 64'd0);
            idle(1);
        end

        // Random traffic with random backpressure.
        for (int i = 0; i < 800; i++) begin
            in_valid   = ($urandom_range(0, 3) != 0);
            A          = pick();
            B          = pick();
            alu_fun    = 1'($urandom_range(0, 1));
            sgn        = 1'($urandom_range(0, 1));
            sat        = 1'($urandom_range(0, 1));
            out_ready2 = ($urandom_range(0, 3) != 0);
            out_ready4 = ($urandom_range(0, 2) != 0);
            @(posedge clk); #1;
        end
        out_ready2 = 1'b1;
        out_ready4 = 1'b1;
        idle(12);
        check("drain2_empty", 64'(exp2_q.size()), 64'd0);
        check("drain4_empty", 64'(exp4_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/add_sub_pipe.md
Name: add_sub_pipe

Overview:
- Parametrised, pipelined successor to the single-cycle ALU adder.
- Performs add/subtract on WIDTH-bit operands, split into STAGES carry-segmented pipeline stages for timing closure at higher clock rates.
- Adds valid/ready flow control, carry-out, corrected unsigned flags and an optional saturation mode.
- Sits in the EX stage and is fed by the ALU operand muxes.

Parameters:
- WIDTH, 32, operand/result width.
- STAGES, 2, pipeline depth and carry-segment count. Legal range 1..8; WIDTH must be divisible by STAGES, otherwise elaboration fails.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operand bundle valid.
- in_ready  output  1  block accepts the bundle this cycle.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- ALUFun  input  1  0 = A+B, 1 = A-B.
- Sign  input  1  1 = signed interpretation, 0 = unsigned.
- Sat  input  1  1 = saturate result on overflow.
- out_valid  output  1  result bundle valid.
- out_ready  input  1  consumer accepts the result.
- S  output  WIDTH  result.
- Z  output  1  S == 0 (final, post-saturation S).
- V  output  1  overflow per Sign.
- N  output  1  true mathematical result < 0.
- C  output  1  raw carry-out of the MSB.

Behaviour:
- Datapath: sum = A + (ALUFun ? ~B : B) + ALUFun, computed over WIDTH+1 bits; C = bit WIDTH.
- Segmentation:
  - Stage k (k = 0..STAGES-1) adds segment k (WIDTH/STAGES bits, LSB segment first) using the carry registered from stage k-1.
  - Unprocessed operand segments, ALUFun, Sign and Sat are carried forward in pipeline registers.
  - The final stage also registers the flags and the saturated result.
- Overflow:
  - Signed overflow = (A[MSB] == Bop[MSB]) & (sum[MSB] != A[MSB]), where Bop = ALUFun ? ~B : B.
  - Unsigned overflow = ALUFun ? ~C : C.
  - V = Sign ? signed overflow : unsigned overflow.
- N:
  - Signed: N = sum[MSB] ^ signed overflow.
  - Unsigned: N = ALUFun & ~C, i.e. A < B on subtract; always 0 on add.
- Saturation (Sat=1 and V=1):
  - Signed: S = N ? {1,0..0} : {0,1..1}.
  - Unsigned add: S = all ones.
  - Unsigned subtract: S = 0.
  - V, N and C still report the raw event. If Sat=0, or V=0, S = sum[WIDTH-1:0].
- Latency and throughput: exactly STAGES cycles from the accepting edge to out_valid, with no stalls. Throughput is one operation per cycle. Results leave in issue order.
- Flow control:
  - Global enable adv = ~out_valid | out_ready. When adv=1, all stages shift one position; when adv=0, all pipeline registers hold.
  - in_ready = adv, combinational.
  - A transfer occurs when in_valid & in_ready.
  - Bubbles (in_valid=0 while adv=1) propagate as invalid entries.
- Stall hold: while out_valid=1 and out_ready=0, S, Z, V, N and C are stable.
- Simultaneous events: output pop and input push in the same cycle is legal and sustains full throughput.
- Reset (sync, active-high):
  - All valid bits clear; out_valid=0; S=0; Z=0; V=0; N=0; C=0. in_ready reads 1 in the cycle after reset.
  - Reset asserted mid-operation discards all in-flight operations; none emerge afterwards.
  - Reset has priority over adv.
- STAGES=1: a single registered stage with one-cycle latency.
- Operand inputs are don't-care when in_valid=0 and must not affect state.

Test Plan (WIDTH=32, STAGES=2 unless stated):
- Signed overflow, add, Sat=0: A=0x7FFFFFFF, B=1, ALUFun=0, Sign=1 -> 2 cycles later S=0x80000000, V=1, N=0, Z=0, C=0.
- Signed overflow, add, Sat=1: same operands -> S=0x7FFFFFFF, V=1.
- Signed overflow, subtract, Sat=1: A=0x80000000, B=1, ALUFun=1, Sign=1 -> S=0x80000000, N=1, V=1.
- Unsigned subtract: A=3, B=5, ALUFun=1, Sign=0, Sat=0 -> S=0xFFFFFFFE, N=1, V=1, C=0. With Sat=1 -> S=0, Z=1.
- Unsigned add overflow: A=0xFFFFFFFF, B=2, ALUFun=0, Sign=0, Sat=1 -> S=0xFFFFFFFF, C=1, V=1, N=0.
- Segment carry and ordering:
  - Back-to-back 0x0000FFFF+1, then 5-5, then 0xFFFFFFFF+1 (Sign=0, Sat=0) on consecutive cycles.
  - Required results on consecutive cycles: 0x00010000; S=0 with Z=1; S=0 with C=1, V=1.
  - Repeat with STAGES=4, WIDTH=32: same values, latency 4.
- Backpressure:
  - Issue 2 operations, then hold out_ready=0 for 3 cycles.
  - Required: in_ready=0 while out_valid=1; S and flags held constant.
  - Releasing out_ready drains both results in order, one per cycle.
- Reset mid-flight: assert reset with 2 operations in flight -> the next cycle shows out_valid=0 and all outputs 0; no stale result ever appears.
